regfile_scoreboard: RTL
=======================

// Module: regfile_scoreboard
// PURPOSE
//  Parametrised multi-port GPR file with a pending-write scoreboard for the decode stage.
//  Provides NUM_RD_PORTS combinational reads with optional same-cycle write-back bypass.
//  Tracks in-flight destination writes per register and raises a stall when an issuing
//  instruction reads an unresolved register, replacing hazard-unit forwarding selects.
// PARAMETERS
//  NUM_REGS      32  architectural registers; x0 hard-wired to zero
//  DATA_SIZE     32  register width in bits
//  NUM_RD_PORTS  2   read ports (source operands per issue)
//  NUM_WB_PORTS  1   write-back ports
//  BYPASS        1   1: wb data forwarded to reads in the same cycle; 0: no bypass
//  PEND_W        2   pending-counter width per register (max 2**PEND_W-1 in flight)
// PORTS  (AW = $clog2(NUM_REGS))
//  i_aclk          in   1                    system clock, rising edge
//  i_areset        in   1                    asynchronous reset, active-high
//  i_issue_valid   in   1                    decode presents an instruction for issue
//  o_issue_ready   out  1                    1 = no hazard, instruction may issue this cycle
//  i_rs_addr       in   NUM_RD_PORTS x AW    source register addresses
//  i_rs_used       in   NUM_RD_PORTS         source p is actually read by the instruction
//  o_rs_data       out  NUM_RD_PORTS x DATA  source operand data
//  i_rd_we         in   1                    issuing instruction writes a destination
//  i_rd_addr       in   AW                   destination register address
//  i_wb_valid      in   NUM_WB_PORTS         write-back strobe per port
//  i_wb_addr       in   NUM_WB_PORTS x AW    write-back address per port
//  i_wb_data       in   NUM_WB_PORTS x DATA  write-back data per port
//  i_flush         in   1                    kill all in-flight instructions
//  o_sb_empty      out  1                    1 = no register has a pending write
// BEHAVIOUR
//  Reset (async, i_areset=1): all registers and pending counters := 0; hence
//   o_rs_data=0, o_issue_ready=1 when no source is used, o_sb_empty=1.
//  Read (comb, 0 latency): addr 0 -> 0. Else if BYPASS and any i_wb_valid[w] hits addr,
//   data = i_wb_data of highest-index hitting port. Else the stored register.
//  Write (clocked): each i_wb_valid[w] with addr!=0 writes; same-address collision ->
//   highest-index port wins. Writes to x0 ignored.
//  Source hazard p: i_rs_used[p] & addr!=0 & pend[addr]!=0, EXCEPT when BYPASS=1 and
//   exactly pend[addr] write-back ports hit addr this cycle (resolves now, bypassed).
//  Dest hazard: i_rd_we & rd!=0 & pend[rd]==2**PEND_W-1 (counter saturated).
//  o_issue_ready = ~i_flush & no source hazard & no dest hazard (independent of
//   i_issue_valid; no combinational path from i_issue_valid).
//  fire = i_issue_valid & o_issue_ready.
//  Counter update per reg r (r!=0), next = pend[r] + (fire & i_rd_we & rd==r)
//   - (count of wb ports hitting r); floored at 0, never wraps. Simultaneous issue
//   and single wb to the same reg -> unchanged.
//  i_flush: next-edge all counters := 0 (overrides issue/wb counting); wb data in the
//   flush cycle is still written. Later wb to a reg with pend=0 writes data and leaves 0.
//  pend[0] is always 0. o_sb_empty = all counters zero (comb from state).
//  Reset asserted mid-operation: state cleared immediately, not at a clock edge.
// TESTING
//  Reset then read x0..x31 on all ports -> all 0; o_sb_empty=1, o_issue_ready=1.
//  Issue rd=x5 (fire), next cycle issue with rs1=x5 used -> o_issue_ready=0; wb x5=0xDEAD
//   same cycle (BYPASS=1) -> o_issue_ready=1, o_rs_data[0]=0xDEAD, pend[x5]=0 after edge.
//  BYPASS=0 variant of the above -> ready stays 0 in wb cycle, rises next cycle, data 0xDEAD.
//  Issue rd=x7 three times (PEND_W=2) -> fourth issue with rd=x7 blocked; one wb x7 -> unblocked.
//  Two wb ports write x9 (0x11 port0, 0x22 port1) same cycle -> x9 reads 0x22.
//  Pending x3,x4 then i_flush -> next cycle o_sb_empty=1; reads of x3 no longer stall.
//  Write x0=0xFFFF and issue rd=x0 -> x0 reads 0, o_sb_empty stays 1.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Multi-port GPR file with a per-register pending-write scoreboard for decode.
// Reads are combinational with optional same-cycle write-back bypass; the
// scoreboard counts in-flight destination writes and withholds issue-ready
// while a used source (or a saturated destination) is still unresolved.
module regfile_scoreboard #(
    parameter int unsigned NUM_REGS     = 32,
    parameter int unsigned DATA_SIZE    = 32,
    parameter int unsigned NUM_RD_PORTS = 2,
    parameter int unsigned NUM_WB_PORTS = 1,
    parameter int unsigned BYPASS       = 1,
    parameter int unsigned PEND_W       = 2,
    localparam int unsigned AW          = $clog2(NUM_REGS)
) (
    input  logic                                   i_aclk,
    input  logic                                   i_areset,
    input  logic                                   i_issue_valid,
    output logic                                   o_issue_ready,
    input  logic [NUM_RD_PORTS-1:0][AW-1:0]        i_rs_addr,
    input  logic [NUM_RD_PORTS-1:0]                i_rs_used,
    output logic [NUM_RD_PORTS-1:0][DATA_SIZE-1:0] o_rs_data,
    input  logic                                   i_rd_we,
    input  logic [AW-1:0]                          i_rd_addr,
    input  logic [NUM_WB_PORTS-1:0]                i_wb_valid,
    input  logic [NUM_WB_PORTS-1:0][AW-1:0]        i_wb_addr,
    input  logic [NUM_WB_PORTS-1:0][DATA_SIZE-1:0] i_wb_data,
    input  logic                                   i_flush,
    output logic                                   o_sb_empty
);

    // Hit-count width covers 0..NUM_WB_PORTS; arithmetic width leaves room for
    // pend + 1 without overflow before the floor-at-zero subtraction.
    localparam int unsigned HW = $clog2(NUM_WB_PORTS + 1);
    localparam int unsigned CW = PEND_W + HW + 1;
    localparam logic [PEND_W-1:0] PendMax = {PEND_W{1'b1}};

    logic [DATA_SIZE-1:0] regs_q [NUM_REGS];
    logic [DATA_SIZE-1:0] regs_d [NUM_REGS];
    logic [PEND_W-1:0]    pend_q [NUM_REGS];
    logic [PEND_W-1:0]    pend_d [NUM_REGS];

    logic [CW-1:0]           wb_hits [NUM_REGS];
    logic [NUM_REGS-1:0]     issue_hit;
    logic [NUM_RD_PORTS-1:0] src_haz;
    logic                    dest_haz;
    logic                    fire;

    // Count how many write-back ports target each register this cycle.
    always_comb begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            wb_hits[r] = '0;
            for (int unsigned w = 0; w < NUM_WB_PORTS; w++) begin
                if (i_wb_valid[w] && (32'(i_wb_addr[w]) == r)) begin
                    wb_hits[r] = wb_hits[r] + CW'(1);
                end
            end
        end
    end

    // Combinational operand read: x0 is zero, latest-index write-back wins the bypass.
    always_comb begin
        for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
            o_rs_data[p] = '0;
            if ((i_rs_addr[p] != '0) && (32'(i_rs_addr[p]) < NUM_REGS)) begin
                o_rs_data[p] = regs_q[i_rs_addr[p]];
                if (BYPASS != 0) begin
                    for (int unsigned w = 0; w < NUM_WB_PORTS; w++) begin
                        if (i_wb_valid[w] && (i_wb_addr[w] == i_rs_addr[p])) begin
                            o_rs_data[p] = i_wb_data[w];
                        end
                    end
                end
            end
        end
    end

    // Source hazards: a pending source stalls unless every outstanding write lands now.
    always_comb begin
        for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
            src_haz[p] = 1'b0;
            if (i_rs_used[p] && (i_rs_addr[p] != '0) && (32'(i_rs_addr[p]) < NUM_REGS)) begin
                if (pend_q[i_rs_addr[p]] != '0) begin
                    src_haz[p] = 1'b1;
                    if ((BYPASS != 0) &&
                        (wb_hits[i_rs_addr[p]] == CW'(pend_q[i_rs_addr[p]]))) begin
                        src_haz[p] = 1'b0;
                    end
                end
            end
        end
    end

    // Destination hazard: a saturated counter cannot accept another in-flight write.
    always_comb begin
        dest_haz = 1'b0;
        if (i_rd_we && (i_rd_addr != '0) && (32'(i_rd_addr) < NUM_REGS)) begin
            dest_haz = (pend_q[i_rd_addr] == PendMax);
        end
    end

    // Ready deliberately ignores i_issue_valid so there is no valid->ready path.
    always_comb begin
        o_issue_ready = ~i_flush & ~(|src_haz) & ~dest_haz;
        fire          = i_issue_valid & o_issue_ready;
    end

    // One-hot of the destination being claimed by an issuing instruction.
    always_comb begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            issue_hit[r] = fire && i_rd_we && (32'(i_rd_addr) == r);
        end
    end

    // Pending-counter next state: +issue -writebacks, floored at zero, flush clears.
    always_comb begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            pend_d[r] = '0;
            if ((r != 0) && !i_flush) begin
                if ((CW'(pend_q[r]) + CW'(issue_hit[r])) > wb_hits[r]) begin
                    pend_d[r] = PEND_W'(CW'(pend_q[r]) + CW'(issue_hit[r]) - wb_hits[r]);
                end
            end
        end
    end

    // Register write next state: ascending port order lets the highest index win.
    always_comb begin
        regs_d = regs_q;
        for (int unsigned w = 0; w < NUM_WB_PORTS; w++) begin
            if (i_wb_valid[w] && (i_wb_addr[w] != '0) && (32'(i_wb_addr[w]) < NUM_REGS)) begin
                regs_d[i_wb_addr[w]] = i_wb_data[w];
            end
        end
        regs_d[0] = '0;
    end

    // Scoreboard is empty when no register has an outstanding write.
    always_comb begin
        o_sb_empty = 1'b1;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if (pend_q[r] != '0) begin
                o_sb_empty = 1'b0;
            end
        end
    end

    // State registers; reset clears storage and counters without waiting for a clock.
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
                pend_q[r] <= '0;
            end
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

endmodule
